// File: rtl/uart_tx_fifo.sv
// Purpose: byte FIFO feeding a Uart8 transmitter through an IDLE/START/WAIT/GAP handshake FSM.
// Latency: a byte written into an empty FIFO while idle raises txStart one clock after the write edge.
// Backpressure: writes to a full FIFO are dropped with an overflow pulse unless a pop frees a slot that cycle.
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int STALL_LIMIT = 1200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     wrEn,
  input  logic [7:0]               wrData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     stall,
  output logic                     txStart,
  output logic [7:0]               txIn,
  input  logic                     txBusy,
  input  logic                     txDone
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } stateT;

  stateT          state;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;
  logic [SW-1:0]  stallCnt;
  logic           pop;
  logic           push;

  // Occupancy flags come from the count so a full buffer is never confused with an empty one.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop only happens from IDLE with a stored byte, so a byte written this cycle can never be popped this cycle.
  assign pop  = (state == IDLE) && en && !empty && !txBusy;
  assign push = wrEn && (!full || pop);

  // Storage array: written at the tail on every accepted push; stale contents are harmless once count is cleared.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wrPtr] <= wrData;
    end
  end

  // Pointer, occupancy and overflow bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wrEn && full && !pop;
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transmit handshake FSM with registered txStart/txIn/stall; en only gates new starts, never an active byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      txStart  <= 1'b0;
      txIn     <= 8'h00;
      stall    <= 1'b0;
      stallCnt <= '0;
    end else begin
      stall <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            txIn     <= mem[rdPtr];
            txStart  <= 1'b1;
            stallCnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (txDone) begin
            // Transmitter finished without ever showing busy.
            txStart <= 1'b0;
            state   <= GAP;
          end else if (txBusy) begin
            txStart <= 1'b0;
            state   <= WAIT;
          end else if (stallCnt == SW'(STALL_LIMIT - 1)) begin
            // Transmitter never accepted the byte: give it up.
            txStart <= 1'b0;
            stall   <= 1'b1;
            state   <= GAP;
          end else begin
            stallCnt <= stallCnt + 1'b1;
          end
        end
        WAIT: begin
          if (txDone || !txBusy) begin
            state <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          txStart <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a stand-in Uart8 transmitter plus a scoreboard of bytes expected in write order.
// Directed sections cover latency, overflow, full-with-pop, en gating, stall timeout and reset mid-transfer.
// A randomized section mixes writes, en toggling and varied transmitter timing.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int SLIM  = 10;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       en     = 1'b0;
  logic       wrEn   = 1'b0;
  logic [7:0] wrData = 8'h00;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       stall;
  logic       txStart;
  logic [7:0] txIn;
  logic       txBusy = 1'b0;
  logic       txDone = 1'b0;

  int errors = 0;
  int checks = 0;

  // Scoreboard: bytes accepted by the FIFO, in the order they must be started.
  logic [7:0] expQ [$];

  int   startsSeen = 0;
  int   ovfSeen    = 0;
  int   stallSeen  = 0;
  int   completed  = 0;
  bit   dead       = 1'b0;
  bit   randModel  = 1'b0;
  int   fixLen     = 4;
  bit   mBusy      = 1'b0;
  int   left       = 0;
  bit   prevStart  = 1'b0;
  int   lowRun     = 0;
  logic [7:0] held = 8'h00;

  uart_tx_fifo #(.DEPTH(DEPTH), .STALL_LIMIT(SLIM)) dut (
    .clk(clk), .reset(reset), .en(en), .wrEn(wrEn), .wrData(wrData),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .stall(stall),
    .txStart(txStart), .txIn(txIn), .txBusy(txBusy), .txDone(txDone)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Downstream transmitter model and output monitor, evaluated on the falling edge.
  initial begin
    bit doneOnly;
    forever begin
      @(negedge clk);
      txDone = 1'b0;
      if (overflow) ovfSeen++;
      if (stall) stallSeen++;
      if (mBusy) begin
        left--;
        if (left <= 0) begin
          mBusy = 1'b0;
          txBusy = 1'b0;
          txDone = 1'b1;
          completed++;
        end
      end
      if (txStart && !prevStart) begin
        if (startsSeen > 0) chk("gap before start", lowRun >= 2, 1);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL order: got unexpected byte %02h, expected none", txIn);
        end else begin
          chk("byte order", txIn, expQ.pop_front());
        end
        held = txIn;
        startsSeen++;
        if (!dead && !mBusy) begin
          doneOnly = randModel ? ($urandom_range(0, 3) == 0) : 1'b0;
          if (doneOnly) begin
            txDone = 1'b1;
            completed++;
          end else begin
            mBusy  = 1'b1;
            txBusy = 1'b1;
            left   = randModel ? int'($urandom_range(1, 8)) : fixLen;
          end
        end
      end else if (txStart) begin
        chk("txIn stable", txIn, held);
      end
      if (txStart) lowRun = 0;
      else lowRun++;
      prevStart = txStart;
    end
  end

  task automatic doWrite(input logic [7:0] b, input bit acc);
    wrEn = 1'b1;
    wrData = b;
    if (acc) expQ.push_back(b);
    @(posedge clk); #1;
    wrEn = 1'b0;
  endtask

  task automatic latencyCheck(input logic [7:0] b);
    en = 1'b1;
    doWrite(b, 1'b1);
    chk("lat count after write", count, 1);
    chk("lat no early start", txStart, 0);
    @(posedge clk); #1;
    chk("lat txStart", txStart, 1);
    chk("lat txIn", txIn, b);
    chk("lat count after pop", count, 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    en = 1'b1;
    while (n < 4000 && !(expQ.size() == 0 && !mBusy && !txStart && !txBusy)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL %s drain: got timeout with %0d bytes pending, expected empty", tag, expQ.size());
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, " count drained"}, count, 0);
    chk({tag, " empty drained"}, empty, 1);
  endtask

  initial begin
    int k0;
    int stallAt;
    int nst;
    bit found;
    int c0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset count", count, 0);
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset txStart", txStart, 0);
    chk("reset txIn", txIn, 8'h00);
    chk("reset overflow", overflow, 0);
    chk("reset stall", stall, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single byte, start latency and loopback value
    latencyCheck(8'h8A);
    drain("single");

    // Fill, overflow, in-order drain
    en = 1'b0;
    k0 = ovfSeen;
    for (int i = 0; i < DEPTH; i++) doWrite(8'(i), 1'b1);
    chk("fill full", full, 1);
    chk("fill count", count, DEPTH);
    doWrite(8'hAA, 1'b0);
    chk("overflow pulse", overflow, 1);
    chk("overflow count kept", count, DEPTH);
    @(posedge clk); #1;
    chk("overflow one cycle", overflow, 0);
    drain("overflow");
    chk("overflow pulses seen", ovfSeen - k0, 1);

    // Write into a full FIFO in the same cycle as a pop
    en = 1'b0;
    for (int i = 0; i < DEPTH; i++) doWrite(8'($urandom), 1'b1);
    k0 = ovfSeen;
    en = 1'b1;
    doWrite(8'h55, 1'b1);
    chk("pop+write count", count, DEPTH);
    chk("pop+write full", full, 1);
    chk("pop+write start", txStart, 1);
    @(posedge clk); #1;
    chk("pop+write no overflow", ovfSeen - k0, 0);
    drain("popwrite");

    // en low blocks starts, raising it sends everything
    en = 1'b0;
    k0 = startsSeen;
    doWrite(8'h11, 1'b1);
    doWrite(8'h22, 1'b1);
    doWrite(8'h33, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("en low count", count, 3);
    chk("en low no starts", startsSeen - k0, 0);
    drain("enable");
    chk("enable starts", startsSeen - k0, 3);

    // Stall timeout with an unresponsive transmitter
    en = 1'b0;
    doWrite(8'h3C, 1'b1);
    doWrite(8'h44, 1'b1);
    dead = 1'b1;
    k0 = stallSeen;
    stallAt = 0;
    nst = 0;
    en = 1'b1;
    @(posedge clk); #1;
    chk("stall first start", txStart, 1);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (stall) begin
        stallAt = k;
        nst++;
      end
      if (k == 11) begin
        chk("stall gap txStart", txStart, 0);
        dead = 1'b0;
      end
      if (k == 12) begin
        chk("stall next start", txStart, 1);
        chk("stall next byte", txIn, 8'h44);
      end
    end
    chk("stall cycle", stallAt, SLIM);
    chk("stall pulse count", nst, 1);
    drain("stall");
    chk("stall pulses seen", stallSeen - k0, 1);

    // Reset while WAIT with five bytes queued
    fixLen = 20;
    en = 1'b0;
    for (int i = 0; i < 6; i++) doWrite(8'(8'hC0 + i), 1'b1);
    en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      if (txBusy && !txStart) found = 1'b1;
    end
    chk("reach wait", found, 1);
    chk("wait count", count, 5);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midreset count", count, 0);
    chk("midreset txStart", txStart, 0);
    chk("midreset empty", empty, 1);
    reset = 1'b1;
    expQ.delete();
    k0 = startsSeen;
    repeat (40) @(posedge clk);
    #1;
    chk("midreset no sends", startsSeen - k0, 0);
    fixLen = 4;
    latencyCheck(8'h77);
    drain("midreset");

    // Randomized traffic
    randModel = 1'b1;
    k0 = ovfSeen;
    nst = stallSeen;
    c0 = completed - startsSeen;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1 && expQ.size() < DEPTH) begin
        wrEn = 1'b1;
        wrData = 8'($urandom);
        expQ.push_back(wrData);
      end else begin
        wrEn = 1'b0;
      end
      @(posedge clk); #1;
    end
    wrEn = 1'b0;
    drain("random");
    chk("random no overflow", ovfSeen - k0, 0);
    chk("random no stall", stallSeen - nst, 0);
    chk("random all completed", completed - startsSeen, c0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, meaning FIFO entries (power of 2, 2..256).
REQ-002 SHALL provide parameter STALL_LIMIT, default 1200, meaning clocks to wait for txBusy after txStart before abandoning a byte.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset: reset=0 sampled at a rising clk edge resets the block.
REQ-005 SHALL have port en  input  1  permits starting new transmissions.
REQ-006 SHALL have port wrEn  input  1  push request.
REQ-007 SHALL have port wrData  input  8  byte to push.
REQ-008 SHALL have port full  output  1  count==DEPTH.
REQ-009 SHALL have port empty  output  1  count==0.
REQ-010 SHALL have port count  output  log2(DEPTH)+1  stored bytes, excluding the byte in flight.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse, write dropped.
REQ-012 SHALL have port stall  output  1  one-cycle pulse, byte abandoned on timeout.
REQ-013 SHALL have port txStart  output  1  start request to the downstream Uart8 transmitter.
REQ-014 SHALL have port txIn  output  8  byte presented to the Uart8 transmitter.
REQ-015 SHALL have port txBusy  input  1  Uart8 transmitter busy.
REQ-016 SHALL have port txDone  input  1  Uart8 transmitter completion pulse.

Function
REQ-017 SHALL store bytes in a circular buffer with read and write pointers wrapping from DEPTH-1 to 0; full/empty SHALL come from count, not pointer equality.
REQ-018 SHALL accept a write when wrEn=1 and (full=0 or a pop occurs in the same cycle); count SHALL then increase by 1 unless a pop coincides, in which case count SHALL be unchanged.
REQ-019 SHALL drop a write when wrEn=1, full=1 and no pop in that cycle, leaving contents unchanged and pulsing overflow for exactly one cycle.
REQ-020 SHALL implement FSM states IDLE, START, WAIT, GAP.
REQ-021 IDLE: when en=1, empty=0 and txBusy=0, SHALL pop the head byte into txIn, set txStart=1 and go to START.
REQ-022 START: SHALL hold txStart=1 with txIn stable; on txBusy=1 SHALL go to WAIT; if txDone=1 is seen first, SHALL go directly to GAP.
REQ-023 START: if txBusy stays 0 for STALL_LIMIT cycles, SHALL drop the byte, pulse stall for one cycle and go to GAP.
REQ-024 WAIT: SHALL deassert txStart, hold txIn, and go to GAP on txDone=1 or on txBusy falling to 0.
REQ-025 GAP: SHALL stay exactly one cycle with txStart=0, then go to IDLE.
REQ-026 Latency: a write sampled at edge E into an empty FIFO while IDLE, en=1 and txBusy=0 SHALL give txStart=1 after edge E+1.
REQ-027 Dropping en mid-transfer SHALL NOT abort the byte in flight; only new starts are blocked.
REQ-028 txStart SHALL be a registered output, asserted only in START.
REQ-029 A write and a pop in the same cycle from an empty FIFO SHALL NOT occur: a popped byte must have been stored before that cycle.

Reset
REQ-030 On reset=0: pointers=0, count=0, empty=1, full=0, overflow=0, stall=0, txStart=0, txIn=8'h00, FSM=IDLE; any in-flight or stored bytes SHALL be discarded.
REQ-031 Reset SHALL take priority over wrEn and all FSM transitions in the same cycle.

Verification
REQ-032 Push 8'b10001010 to an empty FIFO with en=1 -> txStart=1 one edge after the write, txIn=8'h8A, count returns to 0, and Uart8 loopback rxOut=8'h8A.
REQ-033 Push 16 bytes 0x00..0x0F, then push 0xAA while full -> full=1, one overflow pulse, bytes transmitted in order 0x00..0x0F, 0xAA never sent.
REQ-034 Hold txBusy=0 after txStart with STALL_LIMIT=10 -> stall pulses 10 cycles after START entry, and the next byte starts after the GAP cycle.
REQ-035 Push 3 bytes with en=0 -> no txStart and count=3; raise en -> 3 bytes sent, each separated by at least one GAP cycle.
REQ-036 Assert reset=0 during WAIT with count=5 -> at the next edge count=0, txStart=0, FSM=IDLE, and no further bytes are sent.
REQ-037 With the FIFO full, assert wrEn in the same cycle as an IDLE pop -> write accepted, count stays at DEPTH, no overflow pulse.
